lab2_nios_pio_led_out: RTL and testbench

//   Avalon-MM slave output PIO driving board LEDs from the Nios II system; the write-side

---
 rtl/lab2_nios_pio_led_out.sv | 109 ++++++++++
 tb/tb_lab2_nios_pio_led_out.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_nios_pio_led_out.sv
// Avalon-MM output PIO for board LEDs: data register with atomic set/clear,
// per-bit hardware blinking from a programmable half-period counter.
module lab2_nios_pio_led_out #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter logic [31:0] PERIOD_RST  = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] AddrData     = 3'd0;
  localparam logic [2:0] AddrMask     = 3'd1;
  localparam logic [2:0] AddrPeriod   = 3'd2;
  localparam logic [2:0] AddrStatus   = 3'd3;
  localparam logic [2:0] AddrOutSet   = 3'd4;
  localparam logic [2:0] AddrOutClear = 3'd5;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      period_q, period_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [31:0]      readdata_d;
  logic [WIDTH-1:0] out_d;
  logic             wr;
  logic [WIDTH-1:0] wdata;

  assign wr    = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

  // Register writes.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr) begin
      case (address)
        AddrData:     data_d   = wdata;
        AddrMask:     mask_d   = wdata;
        AddrPeriod:   period_d = writedata;
        AddrOutSet:   data_d   = data_q | wdata;
        AddrOutClear: data_d   = data_q & ~wdata;
        default:      ;
      endcase
    end
  end

  // Blink counter; a PERIOD write overrides any wrap on the same edge.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (period_q == 32'd0) begin
      cnt_d   = 32'd0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q) begin
      cnt_d   = 32'd0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
    if (wr && (address == AddrPeriod)) begin
      cnt_d   = 32'd0;
      phase_d = 1'b1;
    end
  end

  // Masked bits follow data in phase 1 and go dark in phase 0.
  assign out_d = data_d & ~(mask_d & {WIDTH{~phase_d}});

  // Read mux samples pre-write register contents.
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      AddrData:   readdata_d = 32'(data_q);
      AddrMask:   readdata_d = 32'(mask_q);
      AddrPeriod: readdata_d = period_q;
      AddrStatus: readdata_d = {31'd0, phase_q};
      default:    readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE[WIDTH-1:0];
      mask_q   <= '0;
      period_q <= PERIOD_RST;
      cnt_q    <= 32'd0;
      phase_q  <= 1'b1;
      readdata <= 32'd0;
      out_port <= RESET_VALUE[WIDTH-1:0];
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      readdata <= readdata_d;
      out_port <= out_d;
    end
  end

endmodule

// File: tb/tb_lab2_nios_pio_led_out.sv
// Self-checking bench for lab2_nios_pio_led_out: directed scenarios plus random
// bus traffic against an elapsed-time model of the blink behaviour.
module tb_lab2_nios_pio_led_out;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int errors = 0;
  int checks = 0;

  // Reference state: blink phase derived from clocks elapsed since PERIOD was set.
  logic [WIDTH-1:0] m_data, m_mask;
  logic [31:0]      m_period;
  longint unsigned  m_t;
  logic [31:0]      m_rd;
  logic [WIDTH-1:0] m_out;

  lab2_nios_pio_led_out #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  function automatic logic phase_of(input logic [31:0] p, input longint unsigned t);
    longint unsigned half;
    if (p == 32'd0) return 1'b1;
    half = longint'(p) + 1;
    return ((t / half) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_data   = '0;
    m_mask   = '0;
    m_period = 32'd0;
    m_t      = 0;
    m_rd     = 32'd0;
    m_out    = '0;
  endtask

  // One bus cycle: drive, clock, update model, sample 1 time unit after the edge.
  task automatic bus(input logic cs, input logic wn, input logic [2:0] addr,
                     input logic [31:0] wd);
    logic ph;
    logic period_wr;
    chipselect = cs;
    write_n    = wn;
    address    = addr;
    writedata  = wd;
    @(posedge clk);
    ph = phase_of(m_period, m_t);
    case (addr)
      3'd0: m_rd = 32'(m_data);
      3'd1: m_rd = 32'(m_mask);
      3'd2: m_rd = m_period;
      3'd3: m_rd = {31'd0, ph};
      default: m_rd = 32'd0;
    endcase
    period_wr = 1'b0;
    if (cs && !wn) begin
      case (addr)
        3'd0: m_data = wd[WIDTH-1:0];
        3'd1: m_mask = wd[WIDTH-1:0];
        3'd2: begin m_period = wd; period_wr = 1'b1; end
        3'd4: m_data = m_data | wd[WIDTH-1:0];
        3'd5: m_data = m_data & ~wd[WIDTH-1:0];
        default: ;
      endcase
    end
    if (period_wr) m_t = 0;
    else m_t = m_t + 1;
    m_out = phase_of(m_period, m_t) ? m_data : (m_data & ~m_mask);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] wd);
    bus(1'b1, 1'b0, addr, wd);
  endtask

  task automatic idle(input logic [2:0] addr);
    bus(1'b0, 1'b1, addr, 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_port !== 8'h00) begin
      errors++; $display("FAIL reset_out got=%h exp=00", out_port);
    end
    checks++;
    if (readdata !== 32'd0) begin
      errors++; $display("FAIL reset_rd got=%h exp=0", readdata);
    end
    idle(3'd3);
    checks++;
    if (readdata !== 32'h1) begin
      errors++; $display("FAIL reset_status got=%h exp=1", readdata);
    end
  endtask

  task automatic test_data();
    wr(3'd0, 32'hA5);
    checks++;
    if (out_port !== 8'hA5) begin
      errors++; $display("FAIL data_out got=%h exp=a5", out_port);
    end
    idle(3'd0);
    checks++;
    if (readdata !== 32'h0000_00A5) begin
      errors++; $display("FAIL data_rd got=%h exp=a5", readdata);
    end
  endtask

  task automatic test_set_clear();
    wr(3'd0, 32'hF0);
    wr(3'd4, 32'h0F);
    checks++;
    if (out_port !== 8'hFF) begin
      errors++; $display("FAIL outset got=%h exp=ff", out_port);
    end
    wr(3'd5, 32'h81);
    checks++;
    if (out_port !== 8'h7E) begin
      errors++; $display("FAIL outclear got=%h exp=7e", out_port);
    end
    idle(3'd4);
    checks++;
    if (readdata !== 32'd0) begin
      errors++; $display("FAIL rd_outset got=%h exp=0", readdata);
    end
    idle(3'd5);
    checks++;
    if (readdata !== 32'd0) begin
      errors++; $display("FAIL rd_outclear got=%h exp=0", readdata);
    end
  endtask

  task automatic test_blink();
    logic exp_b0;
    logic prev_b0;
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h01);
    wr(3'd2, 32'd3);
    prev_b0 = 1'b1;
    // After the PERIOD edge: bit0 high for 4 edges total, then low for 4.
    for (int k = 1; k <= 16; k++) begin
      idle(3'd3);
      exp_b0 = ((k / 4) % 2) == 0;
      checks++;
      if (out_port !== {7'h7F, exp_b0}) begin
        errors++; $display("FAIL blink_out k=%0d got=%h exp=%h", k, out_port, {7'h7F, exp_b0});
      end
      checks++;
      if (readdata !== {31'd0, prev_b0}) begin
        errors++; $display("FAIL blink_status k=%0d got=%h exp=%0d", k, readdata, prev_b0);
      end
      prev_b0 = exp_b0;
    end
  endtask

  task automatic test_wrap_write();
    wr(3'd2, 32'd3);
    repeat (3) idle(3'd0);
    wr(3'd2, 32'd5);
    checks++;
    if (out_port !== 8'hFF) begin
      errors++; $display("FAIL wrap_nowin got=%h exp=ff", out_port);
    end
    repeat (5) idle(3'd0);
    checks++;
    if (out_port !== 8'hFF) begin
      errors++; $display("FAIL wrap_hold got=%h exp=ff", out_port);
    end
    idle(3'd0);
    checks++;
    if (out_port !== 8'hFE) begin
      errors++; $display("FAIL wrap_toggle got=%h exp=fe", out_port);
    end
    wr(3'd2, 32'd0);
    checks++;
    if (out_port !== 8'hFF) begin
      errors++; $display("FAIL period0 got=%h exp=ff", out_port);
    end
    repeat (10) idle(3'd0);
    checks++;
    if (out_port !== 8'hFF) begin
      errors++; $display("FAIL period0_steady got=%h exp=ff", out_port);
    end
  endtask

  task automatic test_ignored();
    wr(3'd1, 32'h00);
    wr(3'd0, 32'h3C);
    bus(1'b0, 1'b0, 3'd0, 32'h11);
    bus(1'b1, 1'b1, 3'd0, 32'h22);
    wr(3'd3, 32'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    checks++;
    if (out_port !== 8'h3C) begin
      errors++; $display("FAIL ignored_out got=%h exp=3c", out_port);
    end
    idle(3'd3);
    checks++;
    if (readdata !== 32'h1) begin
      errors++; $display("FAIL ignored_status got=%h exp=1", readdata);
    end
    idle(3'd6);
    checks++;
    if (readdata !== 32'd0) begin
      errors++; $display("FAIL rd6 got=%h exp=0", readdata);
    end
    wr(3'd0, 32'hFFFF_FF00);
    checks++;
    if (out_port !== 8'h00) begin
      errors++; $display("FAIL wide_out got=%h exp=00", out_port);
    end
    idle(3'd0);
    checks++;
    if (readdata !== 32'd0) begin
      errors++; $display("FAIL wide_rd got=%h exp=0", readdata);
    end
  endtask

  task automatic test_async_reset();
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'd2);
    idle(3'd0);
    checks++;
    if (out_port !== 8'hFF || readdata !== 32'hFF) begin
      errors++; $display("FAIL pre_reset out=%h rd=%h exp=ff/ff", out_port, readdata);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 8'h00 || readdata !== 32'd0) begin
      errors++; $display("FAIL async_reset out=%h rd=%h exp=00/0", out_port, readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    wr(3'd0, 32'h55);
    for (int k = 0; k < 8; k++) begin
      idle(3'd2);
      checks++;
      if (out_port !== 8'h55 || readdata !== 32'd0) begin
        errors++; $display("FAIL post_reset k=%0d out=%h rd=%h exp=55/0", k, out_port, readdata);
      end
    end
  endtask

  task automatic test_random();
    logic        cs, wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    for (int i = 0; i < 400; i++) begin
      cs   = ($urandom_range(0, 3) != 0);
      wn   = ($urandom_range(0, 2) == 0);
      addr = 3'($urandom_range(0, 7));
      wd   = (addr == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
      bus(cs, wn, addr, wd);
      checks++;
      if (out_port !== m_out) begin
        errors++; $display("FAIL rand_out i=%0d got=%h exp=%h", i, out_port, m_out);
      end
      checks++;
      if (readdata !== m_rd) begin
        errors++; $display("FAIL rand_rd i=%0d got=%h exp=%h", i, readdata, m_rd);
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
    model_reset();
    test_reset();
    test_data();
    test_set_clear();
    test_blink();
    test_wrap_write();
    test_ignored();
    test_async_reset();
    apply_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
